booth_pp_gen: RTL and testbench

//  Radix-4 Booth partial-product generator: the producer side of the CSA tree in Booth_Multi.

---
 rtl/booth_pp_gen.sv | 159 +++++++++++++++
 tb/tb_booth_pp_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: radix-4 Booth partial-product generator feeding the CSA tree.
// Operand pairs enter over valid/ready. ROWS two's-complement rows leave after
// PIPE_STAGES register stages. Row i has weight 2^(2i), and the rows sum to A*B mod 2^(2N).
module booth_pp_gen #(
  parameter int N           = 16,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4,
  localparam int ROWS       = N / 2 + 1,
  localparam int PPW        = N + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [N-1:0]        in_a,
  input  logic [N-1:0]        in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROWS*PPW-1:0] out_pp,
  output logic [ROWS-1:0]     out_neg,
  output logic                out_signed,
  output logic [TAG_W-1:0]    out_tag
);
  localparam int DIGW = 3 * ROWS;

  // Each digit is encoded as {neg, two, one}. A zero digit is all-clear, so neg never flags a zero row.
  function automatic logic [2:0] booth_digit(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_digit = 3'b001;
      3'b011:         booth_digit = 3'b010;
      3'b100:         booth_digit = 3'b110;
      3'b101, 3'b110: booth_digit = 3'b101;
      default:        booth_digit = 3'b000;
    endcase
  endfunction

  // The row is d*Ae with the negation fully resolved. 2*Ae and -2*Ae both fit in PPW bits.
  function automatic logic signed [PPW-1:0] select_row(input logic signed [N:0] ae,
                                                       input logic [2:0] dig);
    logic signed [PPW-1:0] mag;
    if (dig[0])      mag = {ae[N], ae};
    else if (dig[1]) mag = {ae, 1'b0};
    else             mag = '0;
    select_row = dig[2] ? -mag : mag;
  endfunction

  logic signed [N:0]     ae_p0;
  logic [N+2:0]          be_p0;
  logic [DIGW-1:0]       dig_p0;

  logic                  sel_vld;
  logic signed [N:0]     sel_ae;
  logic [DIGW-1:0]       sel_dig;
  logic                  sel_sgn;
  logic [TAG_W-1:0]      sel_tag;

  logic [ROWS*PPW-1:0]   pp_d;
  logic [ROWS-1:0]       neg_d;

  logic                  vld_p2;
  logic                  load_p2;
  logic [ROWS*PPW-1:0]   pp_p2;
  logic [ROWS-1:0]       neg_p2;
  logic                  sgn_p2;
  logic [TAG_W-1:0]      tag_p2;

  // Stage 0: extend A and B, then recode B into overlapping triplets with b[-1]=0.
  always_comb begin
    ae_p0  = {in_signed & in_a[N-1], in_a};
    be_p0  = {{2{in_signed & in_b[N-1]}}, in_b, 1'b0};
    dig_p0 = '0;
    for (int i = 0; i < ROWS; i++) begin
      dig_p0[3*i +: 3] = booth_digit(be_p0[2*i +: 3]);
    end
  end

  // The last stage can take a new entry when it is empty or is draining this cycle.
  assign load_p2 = !vld_p2 || out_ready;

  if (PIPE_STAGES == 1) begin : g_one
    // Encode and select share the single register stage.
    assign sel_vld  = in_valid;
    assign sel_ae   = ae_p0;
    assign sel_dig  = dig_p0;
    assign sel_sgn  = in_signed;
    assign sel_tag  = in_tag;
    assign in_ready = load_p2;
  end else begin : g_two
    logic              vld_p1;
    logic              load_p1;
    logic signed [N:0] ae_p1;
    logic [DIGW-1:0]   dig_p1;
    logic              sgn_p1;
    logic [TAG_W-1:0]  tag_p1;

    assign load_p1 = !vld_p1 || load_p2;

    // Stage 1 valid bit: refilled whenever the stage empties or hands its entry on.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       vld_p1 <= 1'b0;
      else if (load_p1) vld_p1 <= in_valid;
    end

    // Stage 1 payload (recoded digits): captured only on an accepted transfer.
    always_ff @(posedge clk) begin
      if (load_p1 && in_valid) begin
        ae_p1  <= ae_p0;
        dig_p1 <= dig_p0;
        sgn_p1 <= in_signed;
        tag_p1 <= in_tag;
      end
    end

    assign sel_vld  = vld_p1;
    assign sel_ae   = ae_p1;
    assign sel_dig  = dig_p1;
    assign sel_sgn  = sgn_p1;
    assign sel_tag  = tag_p1;
    assign in_ready = load_p1;
  end

  // Select and negate each row from the digits of the stage that feeds the output register.
  always_comb begin
    pp_d  = '0;
    neg_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      pp_d[i*PPW +: PPW] = select_row(sel_ae, sel_dig[3*i +: 3]);
      neg_d[i]           = sel_dig[3*i+2];
    end
  end

  // Output stage: the payload holds during a stall and clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      pp_p2  <= '0;
      neg_p2 <= '0;
      sgn_p2 <= 1'b0;
      tag_p2 <= '0;
    end else if (load_p2) begin
      vld_p2 <= sel_vld;
      if (sel_vld) begin
        pp_p2  <= pp_d;
        neg_p2 <= neg_d;
        sgn_p2 <= sel_sgn;
        tag_p2 <= sel_tag;
      end
    end
  end

  assign out_valid  = vld_p2;
  assign out_pp     = pp_p2;
  assign out_neg    = neg_p2;
  assign out_signed = sgn_p2;
  assign out_tag    = tag_p2;

endmodule

// File: tb/tb_booth_pp_gen.sv
// tb_booth_pp_gen: bench for booth_pp_gen.
// Instance 0 uses PIPE_STAGES=1 and instance 1 uses PIPE_STAGES=2.
// Expected rows come from an arithmetic Booth-digit model.
module tb_booth_pp_gen;
  localparam int N     = 16;
  localparam int TAG_W = 4;
  localparam int ROWS  = N / 2 + 1;
  localparam int PPW   = N + 2;
  localparam int PW    = ROWS * PPW;
  localparam int NOPS  = 4000;
  localparam int LIMIT = 30000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]            in_valid, in_ready, in_signed, out_valid, out_ready, out_signed;
  logic [1:0][N-1:0]     in_a, in_b;
  logic [1:0][TAG_W-1:0] in_tag, out_tag;
  logic [1:0][PW-1:0]    out_pp;
  logic [1:0][ROWS-1:0]  out_neg;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    booth_pp_gen #(.N(N), .PIPE_STAGES(g + 1), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_signed(in_signed[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .in_tag(in_tag[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_pp(out_pp[g]),
      .out_neg(out_neg[g]), .out_signed(out_signed[g]), .out_tag(out_tag[g])
    );
  end

  typedef struct {
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             s;
    logic [TAG_W-1:0] tag;
  } op_t;

  int n_cmp = 0;
  int n_err = 0;

  function automatic longint sx(input logic [N-1:0] v, input logic s);
    longint r;
    if (s) r = $signed(v);
    else   r = v;
    return r;
  endfunction

  // Booth digit d_i = -2*b[2i+1] + b[2i] + b[2i-1]. Row i is d_i*Ae truncated to PPW bits.
  function automatic void model(input op_t op, output logic [PW-1:0] pp,
                                output logic [ROWS-1:0] neg);
    longint ae, be, d, prod;
    logic [63:0] bv, pv;
    ae = sx(op.a, op.s);
    be = sx(op.b, op.s);
    bv = be;
    pp = '0;
    neg = '0;
    for (int i = 0; i < ROWS; i++) begin
      d = -2 * longint'(bv[2*i+1]) + longint'(bv[2*i]);
      if (i > 0) d = d + longint'(bv[2*i-1]);
      prod = d * ae;
      pv = prod;
      pp[i*PPW +: PPW] = pv[PPW-1:0];
      neg[i] = (d < 0);
    end
  endfunction

  function automatic logic [2*N-1:0] product(input op_t op);
    logic [63:0] pv;
    pv = sx(op.a, op.s) * sx(op.b, op.s);
    return pv[2*N-1:0];
  endfunction

  function automatic logic [2*N-1:0] row_sum(input logic [PW-1:0] pp);
    longint acc, t;
    logic signed [PPW-1:0] r;
    logic [63:0] av;
    acc = 0;
    for (int i = 0; i < ROWS; i++) begin
      r = pp[i*PPW +: PPW];
      t = r;
      acc = acc + (t <<< (2 * i));
    end
    av = acc;
    return av[2*N-1:0];
  endfunction

  task automatic idle_all;
    in_valid = '0; out_ready = '1; in_signed = '0;
    in_a = '0; in_b = '0; in_tag = '0;
  endtask

  // Send one op with out_ready high and measure cycles from presentation to out_valid.
  task automatic run_op(input int g, input op_t op, output logic [PW-1:0] pp,
                        output logic [ROWS-1:0] neg, output logic [TAG_W-1:0] tag,
                        output logic sg, output int lat);
    int k;
    @(negedge clk);
    in_a[g] = op.a; in_b[g] = op.b; in_signed[g] = op.s; in_tag[g] = op.tag;
    in_valid[g] = 1'b1; out_ready[g] = 1'b1;
    #1;
    k = 0;
    while (!in_ready[g] && k < 20) begin
      @(negedge clk); #1; k++;
    end
    lat = 0;
    do begin
      @(negedge clk);
      in_valid[g] = 1'b0;
      lat++;
      #1;
    end while (!out_valid[g] && lat < 20);
    pp = out_pp[g]; neg = out_neg[g]; tag = out_tag[g]; sg = out_signed[g];
  endtask

  task automatic test_reset;
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      n_cmp++; if (out_valid[g] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d]: got %b want 0", g, out_valid[g]); end
      n_cmp++; if (out_pp[g] !== '0) begin n_err++; $display("FAIL reset_out_pp[%0d]: got %h want 0", g, out_pp[g]); end
      n_cmp++; if (out_neg[g] !== '0) begin n_err++; $display("FAIL reset_out_neg[%0d]: got %h want 0", g, out_neg[g]); end
      n_cmp++; if (out_tag[g] !== '0) begin n_err++; $display("FAIL reset_out_tag[%0d]: got %h want 0", g, out_tag[g]); end
      n_cmp++; if (out_signed[g] !== 1'b0) begin n_err++; $display("FAIL reset_out_signed[%0d]: got %b want 0", g, out_signed[g]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      n_cmp++; if (in_ready[g] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %b want 1", g, in_ready[g]); end
    end
  endtask

  task automatic test_unsigned_max;
    op_t op; logic [PW-1:0] pp, epp; logic [ROWS-1:0] neg; logic [TAG_W-1:0] tag; logic sg; int lat;
    op.a = 16'hFFFF; op.b = 16'hFFFF; op.s = 1'b0; op.tag = 4'hA;
    run_op(1, op, pp, neg, tag, sg, lat);
    epp = '0;
    epp[0 +: PPW]      = 18'h30001;
    epp[8*PPW +: PPW]  = 18'h0FFFF;
    n_cmp++; if (pp !== epp) begin n_err++; $display("FAIL umax_rows: got %h want %h", pp, epp); end
    n_cmp++; if (neg !== 9'h001) begin n_err++; $display("FAIL umax_neg: got %h want 001", neg); end
    n_cmp++; if (row_sum(pp) !== 32'hFFFE0001) begin n_err++; $display("FAIL umax_sum: got %h want fffe0001", row_sum(pp)); end
    n_cmp++; if (tag !== 4'hA || sg !== 1'b0) begin n_err++; $display("FAIL umax_side: got tag %h sgn %b want a 0", tag, sg); end
  endtask

  task automatic test_signed_min;
    op_t op; logic [PW-1:0] pp, epp; logic [ROWS-1:0] neg; logic [TAG_W-1:0] tag; logic sg; int lat;
    op.a = 16'h8000; op.b = 16'h8000; op.s = 1'b1; op.tag = 4'h5;
    run_op(1, op, pp, neg, tag, sg, lat);
    epp = '0;
    epp[7*PPW +: PPW] = 18'h10000;
    n_cmp++; if (pp !== epp) begin n_err++; $display("FAIL smin_rows: got %h want %h", pp, epp); end
    n_cmp++; if (neg !== 9'h080) begin n_err++; $display("FAIL smin_neg: got %h want 080", neg); end
    n_cmp++; if (row_sum(pp) !== 32'h40000000) begin n_err++; $display("FAIL smin_sum: got %h want 40000000", row_sum(pp)); end
    n_cmp++; if (tag !== 4'h5 || sg !== 1'b1) begin n_err++; $display("FAIL smin_side: got tag %h sgn %b want 5 1", tag, sg); end
  endtask

  task automatic test_small_latency;
    op_t op; logic [PW-1:0] pp, epp; logic [ROWS-1:0] neg; logic [TAG_W-1:0] tag; logic sg; int lat;
    op.a = 16'd3; op.b = 16'd5; op.s = 1'b1; op.tag = 4'h3;
    epp = '0;
    epp[0 +: PPW]   = 18'd3;
    epp[PPW +: PPW] = 18'd3;
    for (int g = 0; g < 2; g++) begin
      run_op(g, op, pp, neg, tag, sg, lat);
      n_cmp++; if (pp !== epp) begin n_err++; $display("FAIL small_rows[%0d]: got %h want %h", g, pp, epp); end
      n_cmp++; if (neg !== '0) begin n_err++; $display("FAIL small_neg[%0d]: got %h want 0", g, neg); end
      n_cmp++; if (row_sum(pp) !== 32'd15) begin n_err++; $display("FAIL small_sum[%0d]: got %0d want 15", g, row_sum(pp)); end
      n_cmp++; if (lat != g + 1) begin n_err++; $display("FAIL small_latency[%0d]: got %0d want %0d", g, lat, g + 1); end
    end
  endtask

  task automatic test_back_to_back;
    op_t op; logic [PW-1:0] epp, snap; logic [ROWS-1:0] eneg; int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; snap = '0;
    while (recv < 3 && cyc < 30) begin
      @(negedge clk);
      op.tag = TAG_W'(sent + 1); op.a = N'(16'h1234 * (sent + 1)); op.b = 16'hF00F ^ N'(sent + 1);
      op.s = op.tag[0];
      in_valid[1] = (sent < 3); in_a[1] = op.a; in_b[1] = op.b; in_signed[1] = op.s; in_tag[1] = op.tag;
      out_ready[1] = (cyc >= 5);
      #1;
      if (cyc == 2) snap = out_pp[1];
      if (cyc >= 2 && cyc <= 4) begin
        n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready c%0d: got %b want 0", cyc, in_ready[1]); end
        n_cmp++; if (out_valid[1] !== 1'b1 || out_tag[1] !== 4'd1) begin n_err++; $display("FAIL b2b_hold c%0d: got v%b tag %h want v1 tag 1", cyc, out_valid[1], out_tag[1]); end
        n_cmp++; if (out_pp[1] !== snap) begin n_err++; $display("FAIL b2b_stable c%0d: got %h want %h", cyc, out_pp[1], snap); end
      end
      if (out_valid[1] && out_ready[1]) begin
        op_t e;
        e.tag = TAG_W'(recv + 1); e.a = N'(16'h1234 * (recv + 1)); e.b = 16'hF00F ^ N'(recv + 1); e.s = e.tag[0];
        model(e, epp, eneg);
        n_cmp++; if (out_tag[1] !== e.tag) begin n_err++; $display("FAIL b2b_order: got tag %h want %h", out_tag[1], e.tag); end
        n_cmp++; if (out_pp[1] !== epp) begin n_err++; $display("FAIL b2b_rows tag%0d: got %h want %h", recv + 1, out_pp[1], epp); end
        recv++;
      end
      if (in_valid[1] && in_ready[1]) sent++;
      cyc++;
    end
    @(negedge clk); in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    #1;
    n_cmp++; if (recv != 3 || out_valid[1] !== 1'b0) begin n_err++; $display("FAIL b2b_count: got %0d ops (trailing valid %b) want 3", recv, out_valid[1]); end
  endtask

  task automatic test_reset_midstream;
    op_t op; logic [PW-1:0] pp, epp; logic [ROWS-1:0] neg; logic [TAG_W-1:0] tag; logic sg; int lat; int stale;
    out_ready[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid[1] = 1'b1; in_a[1] = N'(100 + k); in_b[1] = N'(7 + k); in_signed[1] = 1'b0; in_tag[1] = TAG_W'(5 + k);
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0) begin n_err++; $display("FAIL mid_full: got v%b rdy%b want v1 rdy0", out_valid[1], in_ready[1]); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b want 0", out_valid[1]); end
    n_cmp++; if (out_pp[1] !== '0 || out_tag[1] !== '0) begin n_err++; $display("FAIL mid_async_payload: got %h/%h want 0", out_pp[1], out_tag[1]); end
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready[1]); end
    @(negedge clk);
    rst_n = 1'b1; out_ready[1] = 1'b1;
    stale = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (out_valid[1]) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    op.a = 16'h0102; op.b = 16'h0304; op.s = 1'b0; op.tag = 4'h9;
    run_op(1, op, pp, neg, tag, sg, lat);
    model(op, epp, neg);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL mid_latency: got %0d want 2", lat); end
    n_cmp++; if (tag !== 4'h9 || pp !== epp) begin n_err++; $display("FAIL mid_next_op: got tag %h rows %h want tag 9 rows %h", tag, pp, epp); end
  endtask

  task automatic test_random(input int g);
    op_t q[$]; op_t cur, e; logic pend, stall_prev; int sent, got, cyc;
    logic [PW-1:0] epp, pp_prev; logic [ROWS-1:0] eneg; logic [TAG_W-1:0] tag_prev;
    pend = 1'b0; stall_prev = 1'b0; sent = 0; got = 0; cyc = 0;
    pp_prev = '0; tag_prev = '0;
    cur.a = '0; cur.b = '0; cur.s = 1'b0; cur.tag = '0;
    while (got < NOPS && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < NOPS && $urandom_range(3) != 0) begin
        cur.a = N'($urandom); cur.b = N'($urandom); cur.s = 1'($urandom); cur.tag = TAG_W'($urandom);
        pend = 1'b1;
      end
      in_valid[g] = pend; in_a[g] = cur.a; in_b[g] = cur.b; in_signed[g] = cur.s; in_tag[g] = cur.tag;
      out_ready[g] = ($urandom_range(2) != 0);
      #1;
      if (stall_prev) begin
        n_cmp++;
        if (out_valid[g] !== 1'b1 || out_pp[g] !== pp_prev || out_tag[g] !== tag_prev) begin
          n_err++; $display("FAIL rnd%0d_stall: got v%b tag %h want v1 tag %h, rows held", g, out_valid[g], out_tag[g], tag_prev);
        end
      end
      if (out_valid[g] && out_ready[g]) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd%0d_extra: got output tag %h want none", g, out_tag[g]);
        end else begin
          e = q.pop_front();
          model(e, epp, eneg);
          if (out_pp[g] !== epp) begin n_err++; $display("FAIL rnd%0d_rows: got %h want %h", g, out_pp[g], epp); end
          n_cmp++; if (out_neg[g] !== eneg) begin n_err++; $display("FAIL rnd%0d_neg: got %h want %h", g, out_neg[g], eneg); end
          n_cmp++; if (out_tag[g] !== e.tag || out_signed[g] !== e.s) begin n_err++; $display("FAIL rnd%0d_side: got %h/%b want %h/%b", g, out_tag[g], out_signed[g], e.tag, e.s); end
          n_cmp++; if (row_sum(out_pp[g]) !== product(e)) begin n_err++; $display("FAIL rnd%0d_sum: got %h want %h", g, row_sum(out_pp[g]), product(e)); end
          got++;
        end
      end
      if (in_valid[g] && in_ready[g]) begin
        q.push_back(cur); pend = 1'b0; sent++;
      end
      stall_prev = out_valid[g] && !out_ready[g];
      pp_prev = out_pp[g]; tag_prev = out_tag[g];
    end
    @(negedge clk); in_valid[g] = 1'b0; out_ready[g] = 1'b1;
    n_cmp++; if (got != NOPS) begin n_err++; $display("FAIL rnd%0d_count: got %0d ops want %0d", g, got, NOPS); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_min();
    test_small_latency();
    test_back_to_back();
    test_reset_midstream();
    test_random(1);
    test_random(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
